// File: rtl/isa_port_sched.sv
// Shared DRAM read-port scheduler: data commands take strict priority, otherwise
// per-op instruction tables are fetched round-robin, one whole instruction per grant.
module isa_port_sched #(
  parameter int unsigned                  OPNUM       = 3,
  parameter int unsigned                  ADDR_WIDTH  = 16,
  parameter logic [OPNUM-1:0][31:0]       ISANUMWORD  = {32'd2, 32'd2, 32'd16},
  parameter logic [OPNUM-1:0][31:0]       ISANUM      = {32'd18, 32'd32, 32'd23},
  parameter logic [OPNUM-1:0][31:0]       ISABASEADDR = {32'd432, 32'd368, 32'd0}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [OPNUM-1:0]              I_IsaReq,
  input  logic                          I_CmdReq,
  input  logic                          I_CmdDone,
  input  logic                          I_Clear,
  input  logic                          I_RdRdy,
  output logic                          O_CmdGnt,
  output logic [OPNUM-1:0]              O_IsaGnt,
  output logic                          O_RdVld,
  output logic                          O_RdLast,
  output logic [ADDR_WIDTH-1:0]         O_RdAddr,
  output logic [OPNUM-1:0]              O_Exhaust,
  output logic [OPNUM*ADDR_WIDTH-1:0]   O_CntISA
);

  localparam int unsigned IW = (OPNUM > 1) ? $clog2(OPNUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_ISA} state_e;

  state_e                              state_q, state_d;
  logic [IW-1:0]                       sel_q, sel_d;
  logic [IW-1:0]                       rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]               beat_q, beat_d;
  logic [OPNUM-1:0][ADDR_WIDTH-1:0]    ptr_q, ptr_d;
  logic [OPNUM-1:0][ADDR_WIDTH-1:0]    cnt_q, cnt_d;
  logic [OPNUM-1:0]                    exh_q, exh_d;
  logic [OPNUM-1:0]                    isa_gnt_q, isa_gnt_d;
  logic                                cmd_gnt_q, cmd_gnt_d;
  logic                                rd_vld_q, rd_vld_d;
  logic                                rd_last_q, rd_last_d;
  logic [ADDR_WIDTH-1:0]               addr_q, addr_d;

  logic [OPNUM-1:0]                    elig;
  logic                                pick_found;
  logic [IW-1:0]                       pick;
  logic [IW-1:0]                       idx;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    exh_d      = exh_q;
    isa_gnt_d  = isa_gnt_q;
    cmd_gnt_d  = cmd_gnt_q;
    rd_vld_d   = rd_vld_q;
    rd_last_d  = rd_last_q;
    addr_d     = addr_q;
    elig       = I_IsaReq & ~exh_q;
    pick_found = 1'b0;
    pick       = rr_q;
    idx        = rr_q;

    // Descending scan so the nearest eligible op after rr_q is written last
    for (int unsigned k = OPNUM; k >= 1; k--) begin
      idx = IW'((32'(rr_q) + k) % OPNUM);
      if (elig[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (I_CmdReq) begin
          state_d   = S_CMD;
          cmd_gnt_d = 1'b1;
        end else if (pick_found) begin
          state_d         = S_ISA;
          sel_d           = pick;
          rr_d            = pick;
          beat_d          = '0;
          isa_gnt_d       = '0;
          isa_gnt_d[pick] = 1'b1;
          rd_vld_d        = 1'b1;
          addr_d          = ptr_q[pick];
          rd_last_d       = (ISANUMWORD[pick] == 32'd1);
        end
      end
      S_CMD: begin
        if (I_CmdDone) begin
          state_d   = S_IDLE;
          cmd_gnt_d = 1'b0;
        end
      end
      S_ISA: begin
        if (rd_vld_q && I_RdRdy) begin
          if (rd_last_q) begin
            state_d      = S_IDLE;
            beat_d       = '0;
            ptr_d[sel_q] = ptr_q[sel_q] + ADDR_WIDTH'(ISANUMWORD[sel_q]);
            cnt_d[sel_q] = cnt_q[sel_q] + ADDR_WIDTH'(1);
            if (cnt_q[sel_q] + ADDR_WIDTH'(1) == ADDR_WIDTH'(ISANUM[sel_q])) begin
              exh_d[sel_q] = 1'b1;
            end
            isa_gnt_d    = '0;
            rd_vld_d     = 1'b0;
            rd_last_d    = 1'b0;
          end else begin
            beat_d    = beat_q + ADDR_WIDTH'(1);
            addr_d    = addr_q + ADDR_WIDTH'(1);
            rd_last_d = (32'(beat_q) + 32'd2 == ISANUMWORD[sel_q]);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loop restart rewinds every table but keeps round-robin fairness state
    if (I_Clear) begin
      state_d   = S_IDLE;
      beat_d    = '0;
      cnt_d     = '0;
      exh_d     = '0;
      isa_gnt_d = '0;
      cmd_gnt_d = 1'b0;
      rd_vld_d  = 1'b0;
      rd_last_d = 1'b0;
      for (int i = 0; i < OPNUM; i++) begin
        ptr_d[i] = ADDR_WIDTH'(ISABASEADDR[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      rr_q      <= IW'(OPNUM - 1);
      beat_q    <= '0;
      cnt_q     <= '0;
      exh_q     <= '0;
      isa_gnt_q <= '0;
      cmd_gnt_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      addr_q    <= '0;
      for (int i = 0; i < OPNUM; i++) begin
        ptr_q[i] <= ADDR_WIDTH'(ISABASEADDR[i]);
      end
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      exh_q     <= exh_d;
      isa_gnt_q <= isa_gnt_d;
      cmd_gnt_q <= cmd_gnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      addr_q    <= addr_d;
    end
  end

  assign O_CmdGnt  = cmd_gnt_q;
  assign O_IsaGnt  = isa_gnt_q;
  assign O_RdVld   = rd_vld_q;
  assign O_RdLast  = rd_last_q;
  assign O_RdAddr  = addr_q;
  assign O_Exhaust = exh_q;
  assign O_CntISA  = cnt_q;

endmodule

// File: tb/tb_isa_port_sched.sv
// Bench for isa_port_sched: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the port arbitration rules.
module tb_isa_port_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  I_IsaReq;
  logic        I_CmdReq, I_CmdDone, I_Clear, I_RdRdy;
  logic        O_CmdGnt, O_RdVld, O_RdLast;
  logic [2:0]  O_IsaGnt, O_Exhaust;
  logic [15:0] O_RdAddr;
  logic [47:0] O_CntISA;

  isa_port_sched dut (
    .clk(clk), .rst(rst), .I_IsaReq(I_IsaReq), .I_CmdReq(I_CmdReq),
    .I_CmdDone(I_CmdDone), .I_Clear(I_Clear), .I_RdRdy(I_RdRdy),
    .O_CmdGnt(O_CmdGnt), .O_IsaGnt(O_IsaGnt), .O_RdVld(O_RdVld),
    .O_RdLast(O_RdLast), .O_RdAddr(O_RdAddr), .O_Exhaust(O_Exhaust),
    .O_CntISA(O_CntISA)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: op tables indexed FPS=0, BLK=1, GIC=2
  int NW[3]   = '{16, 2, 2};
  int NUM[3]  = '{23, 32, 18};
  int BASE[3] = '{0, 368, 432};
  int m_mode;  // 0 idle, 1 data command, 2 fetching an instruction
  int m_op, m_beat, m_last;
  int m_ptr[3];
  int m_cnt[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [2:0] req, input logic creq, cdone, clr, rdy, rs);
    bit found;
    if (rs) begin
      m_mode = 0; m_beat = 0; m_last = 2; m_op = 0;
      for (int i = 0; i < 3; i++) begin m_ptr[i] = BASE[i]; m_cnt[i] = 0; end
    end else if (clr) begin
      m_mode = 0; m_beat = 0;
      for (int i = 0; i < 3; i++) begin m_ptr[i] = BASE[i]; m_cnt[i] = 0; end
    end else if (m_mode == 0) begin
      if (creq) m_mode = 1;
      else begin
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          int i;
          i = (m_last + k) % 3;
          if (!found && req[i] && m_cnt[i] < NUM[i]) begin
            found = 1; m_op = i; m_last = i; m_beat = 0; m_mode = 2;
          end
        end
      end
    end else if (m_mode == 1) begin
      if (cdone) m_mode = 0;
    end else if (rdy) begin
      if (m_beat == NW[m_op] - 1) begin
        m_ptr[m_op] += NW[m_op];
        m_cnt[m_op] += 1;
        m_beat = 0;
        m_mode = 0;
      end else m_beat++;
    end
  endtask

  task automatic compare_all();
    chk("cmdgnt", O_CmdGnt, m_mode == 1);
    chk("isagnt", O_IsaGnt, (m_mode == 2) ? 3'(1 << m_op) : 3'b000);
    chk("rdvld", O_RdVld, m_mode == 2);
    chk("rdlast", O_RdLast, (m_mode == 2) && (m_beat == NW[m_op] - 1));
    if (m_mode == 2) chk("rdaddr", O_RdAddr, 16'((m_ptr[m_op] + m_beat) % 65536));
    for (int i = 0; i < 3; i++) begin
      chk("exhaust", O_Exhaust[i], m_cnt[i] >= NUM[i]);
      chk("cntisa", O_CntISA[i*16 +: 16], 16'(m_cnt[i]));
    end
  endtask

  task automatic step(input logic [2:0] req, input logic creq, cdone, clr, rdy, rs);
    I_IsaReq = req; I_CmdReq = creq; I_CmdDone = cdone;
    I_Clear = clr; I_RdRdy = rdy; rst = rs;
    @(posedge clk);
    model_edge(req, creq, cdone, clr, rdy, rs);
    @(negedge clk);
    compare_all();
  endtask

  logic [2:0]  sg[4];
  logic [15:0] sa[4];
  int          ns;
  logic        prev_vld;

  initial begin
    // Reset
    step(3'b000, 0, 0, 0, 1, 1);
    step(3'b000, 0, 0, 0, 1, 1);
    chk("rst_addr", O_RdAddr, 16'd0);
    chk("rst_vld", O_RdVld, 1'b0);

    // Single FPS instruction: 16 words from address 0
    step(3'b001, 0, 0, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      chk("fps_addr", O_RdAddr, 16'(k));
      chk("fps_last", O_RdLast, k == 15);
      step(3'b000, 0, 0, 0, 1, 0);
    end
    chk("fps_cnt", O_CntISA[15:0], 16'd1);

    // All ops requesting: BLK, GIC, then FPS from its advanced pointer
    ns = 0; prev_vld = O_RdVld;
    for (int s = 0; s < 23; s++) begin
      step(3'b111, 0, 0, 0, 1, 0);
      if (O_RdVld && !prev_vld && ns < 4) begin sg[ns] = O_IsaGnt; sa[ns] = O_RdAddr; ns++; end
      prev_vld = O_RdVld;
    end
    chk("rr_n", 64'(ns), 64'd3);
    chk("rr_g0", sg[0], 3'b010); chk("rr_a0", sa[0], 16'd368);
    chk("rr_g1", sg[1], 3'b100); chk("rr_a1", sa[1], 16'd432);
    chk("rr_g2", sg[2], 3'b001); chk("rr_a2", sa[2], 16'd16);

    // Command beats a simultaneous BLK request
    step(3'b000, 0, 0, 1, 1, 0);
    step(3'b010, 1, 0, 0, 1, 0);
    chk("cmd_first", O_CmdGnt, 1'b1);
    step(3'b010, 0, 0, 0, 1, 0);
    step(3'b010, 0, 1, 0, 1, 0);
    chk("cmd_drop", O_CmdGnt, 1'b0);
    step(3'b010, 0, 0, 0, 0, 0);
    chk("cmd_blk_addr", O_RdAddr, 16'd368);

    // Backpressure on BLK word 0
    for (int k = 0; k < 5; k++) begin
      step(3'b000, 0, 0, 0, 0, 0);
      chk("stall_addr", O_RdAddr, 16'd368);
      chk("stall_vld", O_RdVld, 1'b1);
    end
    step(3'b000, 0, 0, 0, 1, 0);
    chk("stall_adv", O_RdAddr, 16'd369);
    step(3'b000, 0, 0, 0, 1, 0);

    // Exhaust BLK, confirm it is ignored, then rewind
    step(3'b000, 0, 0, 1, 1, 0);
    for (int n = 0; n < 32; n++) begin
      step(3'b010, 0, 0, 0, 1, 0);
      step(3'b000, 0, 0, 0, 1, 0);
      step(3'b000, 0, 0, 0, 1, 0);
    end
    chk("exh_blk", O_Exhaust[1], 1'b1);
    step(3'b010, 0, 0, 0, 1, 0);
    chk("exh_ignored", O_RdVld, 1'b0);
    step(3'b010, 0, 0, 1, 1, 0);
    chk("clr_exh", O_Exhaust, 3'b000);
    step(3'b010, 0, 0, 0, 1, 0);
    chk("clr_addr", O_RdAddr, 16'd368);
    step(3'b000, 0, 0, 0, 1, 0);

    // Reset during FPS beat 7
    step(3'b000, 0, 0, 1, 1, 0);
    step(3'b001, 0, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) step(3'b000, 0, 0, 0, 1, 0);
    chk("pre_rst_addr", O_RdAddr, 16'd7);
    step(3'b000, 0, 0, 0, 1, 1);
    chk("rst_mid_vld", O_RdVld, 1'b0);
    chk("rst_mid_cnt", O_CntISA[15:0], 16'd0);
    step(3'b001, 0, 0, 0, 1, 0);
    chk("rst_mid_ptr", O_RdAddr, 16'd0);

    // Random traffic
    for (int c = 0; c < 5000; c++) begin
      step(3'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 999) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
